// File: rtl/accum_drain_axis.sv
// accum_drain_axis
// ----------------
// Streams accumulator rows out of the core as a 64-bit AXI-Stream once the
// core has finished. Rows 0..rows-1 are read from the ARRAY_COL accumulator
// banks over a 1-cycle-latency read port. Each ARRAY_COL x 32-bit row is then
// serialised into ARRAY_COL/2 beats. Two row buffers (ping-pong) let the next
// row be fetched while the current one drains. With m_axis_tready held high,
// beats leave back-to-back across row boundaries.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : one-cycle start pulse (ignored while o_busy)
//   cfg_rows        : rows to drain, sampled on an accepted start, saturates at DEPTH
//   o_busy          : high from the accepted start through the o_done cycle
//   o_done          : one-cycle pulse after the final beat handshake
//   o_rd_en         : bank read strobe, broadcast to all banks
//   o_rd_addr       : bank row address
//   i_rd_data       : bank read data, valid the cycle after o_rd_en; bank j at [32j+31:32j]
//   m_axis_tdata    : {col 2b+1, col 2b} for beat b
//   m_axis_tvalid   : beat valid
//   m_axis_tready   : downstream ready
//   m_axis_tlast    : last beat of the last row
//   o_dbg_state     : current FSM state (0 idle, 1 run, 2 done)
//
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both high. m_axis_tvalid, m_axis_tdata and m_axis_tlast
// are functions of registered state only, so they never depend on tready
// within a cycle. They stay stable from the first cycle of valid until that
// beat is transferred.

module accum_drain_axis #(
    parameter int ARRAY_COL  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [ADDR_WIDTH:0]       cfg_rows,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_rd_en,
    output logic [ADDR_WIDTH-1:0]     o_rd_addr,
    input  logic [ARRAY_COL*32-1:0]   i_rd_data,
    output logic [63:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [1:0]                o_dbg_state
);

    localparam int BEATS = ARRAY_COL / 2;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = ADDR_WIDTH + 1;
    localparam logic [RW-1:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic [RW-1:0]            rows_q;

    // Fetch side
    logic [RW-1:0]            fetch_row_q;   // next row to read
    logic                     fetch_buf_q;   // buffer the next read fills
    logic                     rd_en_q;
    logic [ADDR_WIDTH-1:0]    rd_addr_q;
    logic                     rd_buf_q;      // target of the read on the port now
    logic                     cap_q;         // read data arrives this cycle
    logic                     cap_buf_q;     // ... and belongs to this buffer

    // Row buffers
    logic [1:0]               full_q;
    logic [ARRAY_COL*32-1:0]  buf0_q;
    logic [ARRAY_COL*32-1:0]  buf1_q;

    // Drain side
    logic                     drain_buf_q;
    logic [BW-1:0]            beat_q;
    logic [RW-1:0]            drain_row_q;

    logic [RW-1:0]            rows_sat;
    logic                     tvalid;
    logic                     fire;
    logic                     row_end;
    logic                     last_row;
    logic [1:0]               reserved;
    logic [1:0]               free_now;
    logic [1:0]               freeing;
    logic                     issue;
    logic [ARRAY_COL*32-1:0]  sel_row;
    logic [63:0]              beat_data;

    always_comb begin
        rows_sat = (cfg_rows > DEPTH) ? DEPTH : cfg_rows;

        tvalid   = (state_q == S_RUN) && full_q[drain_buf_q];
        fire     = tvalid && m_axis_tready;
        row_end  = fire && (beat_q == LAST_BEAT);
        last_row = (drain_row_q == (rows_q - RW'(1)));

        // A buffer is committed from the edge its read is issued until the
        // edge its data is captured, even though it is not yet full.
        for (int b = 0; b < 2; b++) begin
            reserved[b] = (rd_en_q && (rd_buf_q == b[0])) || (cap_q && (cap_buf_q == b[0]));
            free_now[b] = !full_q[b] && !reserved[b];
            freeing[b]  = row_end && (drain_buf_q == b[0]);
        end

        // Fetch and drain both alternate between the two buffers, so rows
        // leave in order. The buffer being freed this cycle can be refilled at
        // once. It is only ever the fetch target when the other buffer is busy.
        issue = (state_q == S_RUN) && (fetch_row_q < rows_q) &&
                (free_now[fetch_buf_q] || freeing[fetch_buf_q]);

        sel_row   = drain_buf_q ? buf1_q : buf0_q;
        beat_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) begin
                beat_data = sel_row[b*64 +: 64];
            end
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_rd_en       = rd_en_q;
    assign o_rd_addr     = rd_addr_q;
    assign m_axis_tvalid = tvalid;
    assign m_axis_tdata  = tvalid ? beat_data : 64'd0;
    assign m_axis_tlast  = tvalid && (beat_q == LAST_BEAT) && last_row;
    assign o_dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rows_q      <= '0;
            fetch_row_q <= '0;
            fetch_buf_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_buf_q    <= 1'b0;
            cap_q       <= 1'b0;
            cap_buf_q   <= 1'b0;
            full_q      <= 2'b00;
            buf0_q      <= '0;
            buf1_q      <= '0;
            drain_buf_q <= 1'b0;
            beat_q      <= '0;
            drain_row_q <= '0;
        end else begin
            // Bank data arrives one cycle after the strobe.
            cap_q     <= rd_en_q;
            cap_buf_q <= rd_buf_q;
            if (cap_q) begin
                full_q[cap_buf_q] <= 1'b1;
                if (cap_buf_q) begin
                    buf1_q <= i_rd_data;
                end else begin
                    buf0_q <= i_rd_data;
                end
            end
            if (row_end) begin
                full_q[drain_buf_q] <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    rd_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (i_start) begin
                        rows_q      <= rows_sat;
                        beat_q      <= '0;
                        drain_buf_q <= 1'b0;
                        drain_row_q <= '0;
                        busy_q      <= 1'b1;
                        if (rows_sat == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Row 0 is requested on the start edge itself.
                            state_q     <= S_RUN;
                            rd_en_q     <= 1'b1;
                            rd_addr_q   <= '0;
                            rd_buf_q    <= 1'b0;
                            fetch_row_q <= RW'(1);
                            fetch_buf_q <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    rd_en_q <= issue;
                    if (issue) begin
                        rd_addr_q   <= fetch_row_q[ADDR_WIDTH-1:0];
                        rd_buf_q    <= fetch_buf_q;
                        fetch_buf_q <= ~fetch_buf_q;
                        fetch_row_q <= fetch_row_q + RW'(1);
                    end
                    if (fire) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q      <= '0;
                            drain_buf_q <= ~drain_buf_q;
                            drain_row_q <= drain_row_q + RW'(1);
                            if (last_row) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end

                S_DONE: begin
                    rd_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    rd_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_drain_axis.sv
// tb_accum_drain_axis
// -------------------
// Bench for accum_drain_axis. A bank memory model with 1-cycle read latency
// feeds the DUT. Expected beats are built directly from the memory contents:
// row by row, column pairs, with tlast on the final beat. A timed loop then
// follows each drain and compares every transferred beat against that list.

module tb_accum_drain_axis;

    localparam int AC    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int BEATS = AC / 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [AW:0]     cfg_rows;
    logic            o_busy;
    logic            o_done;
    logic            o_rd_en;
    logic [AW-1:0]   o_rd_addr;
    logic [AC*32-1:0] i_rd_data = '0;
    logic [63:0]     m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [1:0]      o_dbg_state;

    logic [31:0]     mem [0:DEPTH-1][0:AC-1];
    logic [64:0]     exp_q[$];
    int              tests = 0;
    int              fails = 0;

    accum_drain_axis #(.ARRAY_COL(AC), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .cfg_rows      (cfg_rows),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_rd_en       (o_rd_en),
        .o_rd_addr     (o_rd_addr),
        .i_rd_data     (i_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .o_dbg_state   (o_dbg_state)
    );

    always #5 clk = ~clk;

    // Accumulator banks: registered read, data valid the cycle after o_rd_en.
    always @(posedge clk) begin
        if (o_rd_en) begin
            for (int j = 0; j < AC; j++) begin
                i_rd_data[j*32 +: 32] <= mem[o_rd_addr][j];
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < AC; j++)
                mem[i][j] = 32'(i * 16 + j);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < AC; j++) begin
                mem[i][j] = $urandom;
                case ($urandom_range(0, 7))
                    0: mem[i][j] = 32'h8000_0000;
                    1: mem[i][j] = 32'hFFFF_FFFF;
                    default: ;
                endcase
            end
        mem[0][0] = 32'h8000_0000;
        mem[0][1] = 32'hFFFF_FFFF;
    endtask

    // rdy_mode: 0 = tready high, 1 = random 50%, 2 = low for the first 10 cycles.
    // restart_at: cycle at which a second start (cfg_rows=5) is pulsed, or -1.
    // rst_at_beat: number of accepted beats after which reset is applied, or -1.
    task automatic run_drain(input int rows_cfg, input int rdy_mode,
                             input int restart_at, input int rst_at_beat);
        int rows_eff, total, cyc, beat_cnt, done_cnt, done_cyc, last_hs;
        int rden_cnt, rows_freed, first_tv, bubbles, tv_cnt, budget, tail_end;
        logic prev_v, prev_r, was_reset, finished;
        logic [64:0] prev_beat, exp_b;

        rows_eff = (rows_cfg > DEPTH) ? DEPTH : rows_cfg;
        total    = rows_eff * BEATS;
        exp_q.delete();
        for (int r = 0; r < rows_eff; r++)
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back({(r == rows_eff - 1) && (b == BEATS - 1),
                                 mem[r][2*b+1], mem[r][2*b]});

        beat_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
        rden_cnt = 0; rows_freed = 0; first_tv = -1; bubbles = 0; tv_cnt = 0;
        tail_end = -1; prev_v = 1'b0; prev_r = 1'b0; prev_beat = '0;
        was_reset = 1'b0; finished = 1'b0;
        budget = total * 4 + 100;

        @(posedge clk); #1;
        i_start       = 1'b1;
        cfg_rows      = 9'(rows_cfg);
        m_axis_tready = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc = -1;

        while (!finished) begin
            @(posedge clk); cyc++; #1;
            i_start = 1'b0;

            if (rst) begin
                rst = 1'b0;
                check("rst_tvalid", m_axis_tvalid, 1'b0);
                check("rst_busy",   o_busy,        1'b0);
                check("rst_done",   o_done,        1'b0);
                check("rst_tlast",  m_axis_tlast,  1'b0);
                check("rst_rd_en",  o_rd_en,       1'b0);
                check("rst_tdata",  m_axis_tdata,  64'd0);
                exp_q.delete();
                prev_v = 1'b0;
                rden_cnt = 0; rows_freed = 0;
                tail_end = cyc + 20;
            end

            if (cyc == 0) check("busy_start", o_busy, 1'b1);
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_rd_en) begin
                rden_cnt++;
                check("buffered_rows_le2", 32'(rden_cnt - rows_freed <= 2), 32'd1);
            end
            if (m_axis_tvalid) begin
                tv_cnt++;
                if (first_tv < 0) first_tv = cyc;
            end else if (first_tv >= 0 && beat_cnt < total && !was_reset) begin
                bubbles++;
            end
            if (prev_v && !prev_r)
                check("stall_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});

            if (restart_at == cyc) begin
                i_start  = 1'b1;
                cfg_rows = 9'd5;
            end
            if (!was_reset && rst_at_beat >= 0 && beat_cnt == rst_at_beat) begin
                rst = 1'b1;
                m_axis_tready = 1'b0;
                was_reset = 1'b1;
            end else begin
                case (rdy_mode)
                    0:       m_axis_tready = 1'b1;
                    1:       m_axis_tready = 1'($urandom_range(0, 1));
                    default: m_axis_tready = (cyc >= 10);
                endcase
            end

            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check("beat", {m_axis_tlast, m_axis_tdata}, exp_b);
                end else begin
                    check("extra_beat", m_axis_tvalid, 1'b0);
                end
                beat_cnt++;
                if (beat_cnt % BEATS == 0) rows_freed++;
                last_hs = cyc + 1;
            end
            prev_v    = m_axis_tvalid;
            prev_r    = m_axis_tready;
            prev_beat = {m_axis_tlast, m_axis_tdata};

            if (done_cyc >= 0 && cyc > done_cyc) finished = 1'b1;
            if (tail_end >= 0 && cyc >= tail_end) finished = 1'b1;
            if (cyc > budget) begin
                check("timeout", cyc, budget);
                finished = 1'b1;
            end
        end

        m_axis_tready = 1'b0;
        if (rst_at_beat >= 0) begin
            check("rst_no_done", done_cnt, 0);
        end else begin
            check("beat_count",  beat_cnt, total);
            check("exp_left",    exp_q.size(), 0);
            check("done_count",  done_cnt, 1);
            check("rd_en_count", rden_cnt, rows_eff);
            check("busy_end",    o_busy, 1'b0);
            if (rows_eff > 0) begin
                check("done_after_last", done_cyc, last_hs);
                check("first_tvalid_le3", 32'(first_tv >= 0 && first_tv <= 3), 32'd1);
                if (rdy_mode == 0) check("bubbles", bubbles, 0);
            end else begin
                check("zero_rows_tvalid", tv_cnt, 0);
                check("zero_rows_done_lat", 32'(done_cyc >= 0 && done_cyc <= 2), 32'd1);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        i_start       = 1'b0;
        cfg_rows      = '0;
        m_axis_tready = 1'b0;
        fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   o_busy,        1'b0);
        check("reset_done",   o_done,        1'b0);
        check("reset_rd_en",  o_rd_en,       1'b0);
        check("reset_addr",   o_rd_addr,     8'd0);
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tlast",  m_axis_tlast,  1'b0);
        check("reset_tdata",  m_axis_tdata,  64'd0);
        rst = 1'b0;

        // 18 rows of ramp data, no backpressure
        run_drain(18, 0, -1, -1);
        // 18 rows of signed random data, random backpressure
        fill_random();
        run_drain(18, 1, -1, -1);
        // zero rows
        run_drain(0, 0, -1, -1);
        // single row with tready held low at first
        run_drain(1, 2, -1, -1);
        // start re-pulsed mid-drain must be ignored
        fill_ramp();
        run_drain(18, 0, 30, -1);
        // reset after beat 40, then a fresh 2-row drain
        run_drain(18, 0, -1, 40);
        run_drain(2, 0, -1, -1);
        // cfg_rows above DEPTH saturates to DEPTH rows
        fill_random();
        run_drain(300, 1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
